// File: rtl/recarga_quiosque.sv
// rtl/recarga_quiosque.sv - coin-fed two-card recharge kiosk with shadow card balances
module recarga_quiosque (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       moeda,
  input  logic       sel,
  input  logic       confirma,
  input  logic       cancela,
  input  logic       debita1,
  input  logic       debita2,
  output logic [1:0] carrega1,
  output logic [1:0] carrega2,
  output logic [2:0] credito,
  output logic [2:0] troco,
  output logic       rejeita,
  output logic       ocupado
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ACUMULA = 2'd1;
  localparam logic [1:0] ENTREGA = 2'd2;
  localparam logic [1:0] DEVOLVE = 2'd3;

  logic [1:0] state, state_n;
  logic       moeda_q;
  logic       sel_q, sel_n;
  logic [2:0] saldo1, saldo2, saldo1_n, saldo2_n;
  logic [2:0] credito_n, troco_n;
  logic [1:0] carrega1_n, carrega2_n;
  logic       rejeita_n, ocupado_n;

  logic       coin;
  logic [2:0] cap1, cap2;
  logic [1:0] ent1, ent2;
  logic [2:0] sobra;
  logic [1:0] load1, load2;
  logic [2:0] sum1, sum2;
  logic       dec1, dec2;

  // Coin event and how much each card can still absorb right now
  always_comb begin
    coin = moeda & ~moeda_q;
    cap1 = 3'd5 - saldo1;
    cap2 = 3'd5 - saldo2;
    ent1 = (credito < cap1) ? credito[1:0] : cap1[1:0];
    ent2 = (credito < cap2) ? credito[1:0] : cap2[1:0];
    sobra = credito - (sel_q ? {1'b0, carrega2} : {1'b0, carrega1});
  end

  // Next-state and next-output logic; the load amount is fixed on entry to ENTREGA
  always_comb begin
    state_n    = state;
    credito_n  = credito;
    sel_n      = sel_q;
    carrega1_n = 2'd0;
    carrega2_n = 2'd0;
    troco_n    = 3'd0;
    rejeita_n  = 1'b0;
    case (state)
      OCIOSO: begin
        credito_n = 3'd0;
        if (coin) begin
          credito_n = 3'd1;
          state_n   = ACUMULA;
        end
      end
      ACUMULA: begin
        if (cancela) begin
          troco_n   = credito;
          credito_n = 3'd0;
          rejeita_n = coin;
          state_n   = DEVOLVE;
        end else if (confirma) begin
          sel_n     = sel;
          rejeita_n = coin;
          if (sel) carrega2_n = ent2;
          else     carrega1_n = ent1;
          state_n   = ENTREGA;
        end else if (coin) begin
          if (credito < 3'd3) credito_n = credito + 3'd1;
          else                rejeita_n = 1'b1;
        end
      end
      ENTREGA: begin
        rejeita_n = coin;
        credito_n = 3'd0;
        if (sobra != 3'd0) begin
          troco_n = sobra;
          state_n = DEVOLVE;
        end else begin
          state_n = OCIOSO;
        end
      end
      default: begin
        rejeita_n = coin;
        credito_n = 3'd0;
        state_n   = OCIOSO;
      end
    endcase
    ocupado_n = (state_n == ENTREGA) || (state_n == DEVOLVE);
  end

  // Shadow balances: the load lands as ENTREGA ends, merged with any debit that cycle
  always_comb begin
    load1    = (state == ENTREGA && !sel_q) ? carrega1 : 2'd0;
    load2    = (state == ENTREGA &&  sel_q) ? carrega2 : 2'd0;
    sum1     = saldo1 + {1'b0, load1};
    sum2     = saldo2 + {1'b0, load2};
    dec1     = debita1 & ~debita2 & (sum1 != 3'd0);
    dec2     = debita2 & ~debita1 & (sum2 != 3'd0);
    saldo1_n = sum1 - {2'b00, dec1};
    saldo2_n = sum2 - {2'b00, dec2};
  end

  // State and registered outputs
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state    <= OCIOSO;
      moeda_q  <= 1'b0;
      sel_q    <= 1'b0;
      saldo1   <= 3'd0;
      saldo2   <= 3'd0;
      credito  <= 3'd0;
      carrega1 <= 2'd0;
      carrega2 <= 2'd0;
      troco    <= 3'd0;
      rejeita  <= 1'b0;
      ocupado  <= 1'b0;
    end else begin
      state    <= state_n;
      moeda_q  <= moeda;
      sel_q    <= sel_n;
      saldo1   <= saldo1_n;
      saldo2   <= saldo2_n;
      credito  <= credito_n;
      carrega1 <= carrega1_n;
      carrega2 <= carrega2_n;
      troco    <= troco_n;
      rejeita  <= rejeita_n;
      ocupado  <= ocupado_n;
    end
  end

endmodule

// File: tb/tb_recarga_quiosque.sv
// tb/tb_recarga_quiosque.sv - scoreboard bench for recarga_quiosque
module tb_recarga_quiosque;

  logic       clk_2 = 1'b0;
  logic       reset, moeda, sel, confirma, cancela, debita1, debita2;
  logic [1:0] carrega1, carrega2;
  logic [2:0] credito, troco;
  logic       rejeita, ocupado;

  typedef struct packed {
    logic [1:0] c1;
    logic [1:0] c2;
    logic [2:0] tr;
    logic       rej;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  recarga_quiosque dut (
    .clk_2(clk_2), .reset(reset), .moeda(moeda), .sel(sel),
    .confirma(confirma), .cancela(cancela), .debita1(debita1), .debita2(debita2),
    .carrega1(carrega1), .carrega2(carrega2), .credito(credito), .troco(troco),
    .rejeita(rejeita), .ocupado(ocupado)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic coin();
    moeda = 1'b1; tick();
    moeda = 1'b0; tick();
  endtask

  task automatic push(input int c1, input int c2, input int tr, input int rej);
    ev_t e;
    e.c1 = c1[1:0]; e.c2 = c2[1:0]; e.tr = tr[2:0]; e.rej = rej[0];
    exp_q.push_back(e);
  endtask

  // Confirm delivery to a card: one cycle in ENTREGA, optional debit during it
  task automatic deliver(input logic s, input logic deb2_in_entrega);
    sel = s; confirma = 1'b1; tick();
    confirma = 1'b0; debita2 = deb2_in_entrega; tick();
    debita2 = 1'b0; tick();
  endtask

  // Monitor: every nonzero event output must match the oldest expected event
  always @(negedge clk_2) begin
    if (!reset && (carrega1 != 0 || carrega2 != 0 || troco != 0 || rejeita)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual=c1:%0d c2:%0d tr:%0d rej:%0d required=none",
                 carrega1, carrega2, troco, rejeita);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (carrega1 != e.c1 || carrega2 != e.c2 || troco != e.tr || rejeita != e.rej) begin
          errors++;
          $display("FAIL event actual=c1:%0d c2:%0d tr:%0d rej:%0d required=c1:%0d c2:%0d tr:%0d rej:%0d",
                   carrega1, carrega2, troco, rejeita, e.c1, e.c2, e.tr, e.rej);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; moeda = 0; sel = 0; confirma = 0; cancela = 0; debita1 = 0; debita2 = 0;
    #1;
    chk("reset_credito", credito, 0);
    chk("reset_ocupado", ocupado, 0);
    tick(); tick();
    reset = 1'b0;

    // debit at zero balance does not underflow
    debita1 = 1'b1; tick(); debita1 = 1'b0;
    chk("saldo1_no_underflow", dut.saldo1, 0);

    // 2 coins to card 1
    coin(); coin();
    chk("credito_after_2", credito, 2);
    push(2, 0, 0, 0);
    sel = 0; confirma = 1'b1; tick();
    chk("ocupado_entrega", ocupado, 1);
    confirma = 1'b0; tick();
    chk("saldo1_2", dut.saldo1, 2);
    chk("state_idle_35", dut.state, 0);

    // bring saldo1 to 4, then 3 coins: load 1, return 2
    coin(); coin(); push(2, 0, 0, 0); deliver(0, 0);
    chk("saldo1_4", dut.saldo1, 4);
    coin(); coin(); coin();
    push(1, 0, 0, 0); push(0, 0, 2, 0);
    deliver(0, 0);
    chk("saldo1_5", dut.saldo1, 5);

    // full card: whole credit returned
    coin(); push(0, 0, 1, 0); deliver(0, 0);
    chk("saldo1_stays_5", dut.saldo1, 5);

    // 4 coins: cap at 3 with one refusal, then cancel
    coin(); coin(); coin();
    push(0, 0, 0, 1);
    coin();
    chk("credito_cap", credito, 3);
    push(0, 0, 3, 0);
    cancela = 1'b1; tick(); cancela = 1'b0;
    chk("credito_devolve", credito, 0);
    tick();
    chk("state_idle_37", dut.state, 0);

    // confirma and cancela together: cancel wins
    coin(); coin();
    push(0, 0, 2, 0);
    confirma = 1'b1; cancela = 1'b1; tick(); confirma = 1'b0; cancela = 1'b0;
    tick();

    // card 2 to 3, simultaneous debits ignored, single debit applies
    coin(); coin(); coin(); push(0, 3, 0, 0); deliver(1, 0);
    chk("saldo2_3", dut.saldo2, 3);
    debita1 = 1'b1; debita2 = 1'b1; tick(); debita1 = 1'b0; debita2 = 1'b0;
    chk("saldo1_both_deb", dut.saldo1, 5);
    chk("saldo2_both_deb", dut.saldo2, 3);
    debita2 = 1'b1; tick(); debita2 = 1'b0;
    chk("saldo2_deb", dut.saldo2, 2);

    // load and debit to card 2 in the same cycle: 2 + 2 - 1
    coin(); coin(); push(0, 2, 0, 0); deliver(1, 1);
    chk("saldo2_load_deb", dut.saldo2, 3);

    // reset in the middle of ENTREGA
    coin(); coin(); push(0, 2, 0, 0);
    sel = 1; confirma = 1'b1; tick(); confirma = 1'b0;
    @(negedge clk_2); #1;
    reset = 1'b1; #1;
    chk("rst_carrega2", carrega2, 0);
    chk("rst_credito", credito, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_troco", troco, 0);
    chk("rst_saldo1", dut.saldo1, 0);
    chk("rst_saldo2", dut.saldo2, 0);
    chk("rst_state", dut.state, 0);
    tick(); reset = 1'b0;
    tick(); tick(); tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recarga_quiosque.md
RECARGA_QUIOSQUE -- requirements
Module: recarga_quiosque

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset, as below.
REQ-002 clk_2  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 moeda  input  1  coin sensor level; each 0->1 transition sampled at clk_2 is one coin (1 unit).
REQ-005 sel  input  1  target card: 0 = passenger 1, 1 = passenger 2; sampled on the confirming cycle.
REQ-006 confirma  input  1  level; request delivery of accumulated credit.
REQ-007 cancela  input  1  level; abort and return accumulated credit.
REQ-008 debita1, debita2  input  1 each  turnstile debit pulses, one unit per high cycle.
REQ-009 carrega1, carrega2  output  2 each  load value to card 1/2, nonzero for exactly one cycle per delivery.
REQ-010 credito  output  3  credit currently accumulated (0..3).
REQ-011 troco  output  3  returned-coin count, nonzero for exactly one cycle per return.
REQ-012 rejeita  output  1  one-cycle pulse when a coin is refused.
REQ-013 ocupado  output  1  high in ENTREGA and DEVOLVE.

Function
REQ-014 FSM states: OCIOSO, ACUMULA, ENTREGA, DEVOLVE; all outputs registered.
REQ-015 Coin edge detect: a coin event occurs in a cycle where moeda=1 and its value sampled at the previous edge was 0.
REQ-016 OCIOSO: credito=0; coin event -> credito=1, go ACUMULA; confirma/cancela ignored.
REQ-017 ACUMULA, priority order: cancela, then confirma, then coin.
REQ-018 ACUMULA + cancela (with or without confirma) -> DEVOLVE with pending return = credito.
REQ-019 ACUMULA + confirma, no cancela -> latch sel, go ENTREGA.
REQ-020 ACUMULA + coin event, no confirma/cancela: credito<3 -> credito+1; credito=3 -> credito unchanged, rejeita=1 next cycle.
REQ-021 Coin event in the same cycle as confirma or cancela, or in ENTREGA or DEVOLVE, SHALL be refused with a rejeita pulse.
REQ-022 Shadow balances saldo1, saldo2 (3 bits, 0..5) SHALL track each card's stored value.
REQ-023 ENTREGA, one cycle: for latched card N, entrega = min(credito, 5 - saldoN); carregaN = entrega; other carrega = 0; sobra = credito - entrega.
REQ-024 Leaving ENTREGA: credito -> 0; sobra>0 -> DEVOLVE with pending return = sobra, else -> OCIOSO.
REQ-025 DEVOLVE, one cycle: troco = pending return; credito = 0; then -> OCIOSO.
REQ-026 Outside ENTREGA, carrega1 = carrega2 = 0; outside DEVOLVE, troco = 0.
REQ-027 Debits: debita1 XOR debita2 high -> that saldo decrements by 1 if >0, else unchanged.
REQ-028 debita1 and debita2 high together SHALL both be ignored.
REQ-029 Debit and load to the same card in the same cycle: saldo_next = saldoN + entrega - (1 if saldoN + entrega > 0).
REQ-030 saldo SHALL never exceed 5 or underflow below 0.
REQ-031 confirma held high across cycles SHALL NOT trigger a second delivery; a new delivery requires returning to ACUMULA with credit.

Reset
REQ-032 On reset: state=OCIOSO; credito=0, saldo1=saldo2=0; carrega1=carrega2=0, troco=0, rejeita=0, ocupado=0; coin edge history=0.
REQ-033 Reset during ENTREGA or DEVOLVE SHALL discard the pending load or return with no output pulse.
REQ-034 After reset is released, the block SHALL act on the first rising clk_2 edge.

Verification
REQ-035 Scenario: 2 coin edges, sel=0, confirma -> carrega1=2 for one cycle, saldo1=2, troco never nonzero, back to OCIOSO.
REQ-036 Scenario: saldo1=4, 3 coins, confirma sel=0 -> carrega1=1, next cycle troco=2, saldo1=5.
REQ-037 Scenario: 4 coin edges -> credito=3, rejeita pulses once; then cancela -> troco=3 one cycle, credito=0.
REQ-038 Scenario: confirma and cancela together with credito=2 -> troco=2, carrega1=carrega2=0.
REQ-039 Scenario: saldo2=3, debita1=debita2=1 one cycle -> saldo1, saldo2 unchanged; then debita2 alone -> saldo2=2.
REQ-040 Scenario: reset asserted mid-ENTREGA -> all outputs 0 immediately without a clock edge, saldo1=saldo2=0, state OCIOSO.
